// File: rtl/conway_pkg.sv
// Shared types and helpers for the 3D cellular automaton engine.
// Optional build macro: CONWAY_WRAP_EN (toroidal neighbourhood).
package conway_pkg;

    typedef enum logic [2:0] {
        ST_SETUP = 3'b100,
        ST_SIMUL = 3'b010,
        ST_PAUSE = 3'b001
    } state_e;

    localparam int NBR_CNT = 26;

    function automatic int cell_idx(input int x, input int y, input int z, input int n);
        return x + n * y + n * n * z;
    endfunction

endpackage

// File: rtl/conway_cell_next.sv
// Next-generation rule for a single cell given its 26 neighbours.
module conway_cell_next
    import conway_pkg::*;
#(
    parameter int SURV_MIN  = 4,
    parameter int SURV_MAX  = 5,
    parameter int BIRTH_MIN = 5,
    parameter int BIRTH_MAX = 5
) (
    input  logic [NBR_CNT-1:0] nbr_i,
    input  logic               cell_i,
    output logic               next_o
);

    logic [4:0] cnt_s;

    always_comb begin
        cnt_s = 5'd0;
        for (int i = 0; i < NBR_CNT; i++) begin
            cnt_s = cnt_s + {4'd0, nbr_i[i]};
        end
    end

    always_comb begin
        next_o = 1'b0;
        if (cell_i) begin
            next_o = (cnt_s >= 5'(SURV_MIN)) && (cnt_s <= 5'(SURV_MAX));
        end else begin
            next_o = (cnt_s >= 5'(BIRTH_MIN)) && (cnt_s <= 5'(BIRTH_MAX));
        end
    end

endmodule

// File: rtl/conway_engine.sv
// N x N x N cellular automaton with SETUP/SIMUL/PAUSE control.
// Optional build macro: CONWAY_WRAP_EN (toroidal neighbourhood).
module conway_engine
    import conway_pkg::*;
#(
    parameter int N         = 8,
    parameter int TICK_DIV  = 4,
    parameter int SURV_MIN  = 4,
    parameter int SURV_MAX  = 5,
    parameter int BIRTH_MIN = 5,
    parameter int BIRTH_MAX = 5
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   BtnR,
    input  logic                   BtnL,
    input  logic                   Sw0,
    input  logic                   WrEn,
    input  logic [3*$clog2(N)-1:0] WrAddr,
    input  logic                   WrData,
    output logic [N*N*N-1:0]       Cells,
    output logic [15:0]            GenCount,
    output logic                   Extinct,
    output logic                   q_setup,
    output logic                   q_simul,
    output logic                   q_pause
);

    localparam int NC = N * N * N;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    state_e          state_q, state_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [15:0]     gen_q, gen_d;
    logic [NC-1:0]   cells_q, cells_d;
    logic [NC-1:0]   next_s;
    logic            tick_last_s;

    assign tick_last_s = (tick_q == TW'(TICK_DIV - 1));

    // Neighbour gathering is fixed wiring; only the edge policy depends on the build.
    for (genvar gz = 0; gz < N; gz++) begin : g_z
        for (genvar gy = 0; gy < N; gy++) begin : g_y
            for (genvar gx = 0; gx < N; gx++) begin : g_x
                localparam int CIDX = cell_idx(gx, gy, gz, N);
                logic [NBR_CNT-1:0] nbr_s;

                for (genvar gk = 0; gk < 27; gk++) begin : g_k
                    if (gk != 13) begin : g_real
                        localparam int DX   = (gk % 3) - 1;
                        localparam int DY   = ((gk / 3) % 3) - 1;
                        localparam int DZ   = (gk / 9) - 1;
                        localparam int SLOT = (gk < 13) ? gk : gk - 1;
                        localparam int NX   = gx + DX;
                        localparam int NY   = gy + DY;
                        localparam int NZ   = gz + DZ;
`ifdef CONWAY_WRAP_EN
                        localparam int WIDX = cell_idx((NX + N) % N, (NY + N) % N, (NZ + N) % N, N);
                        assign nbr_s[SLOT] = cells_q[WIDX];
`else
                        if ((NX >= 0) && (NX < N) && (NY >= 0) && (NY < N) &&
                            (NZ >= 0) && (NZ < N)) begin : g_in
                            localparam int NIDX = cell_idx(NX, NY, NZ, N);
                            assign nbr_s[SLOT] = cells_q[NIDX];
                        end else begin : g_out
                            assign nbr_s[SLOT] = 1'b0;
                        end
`endif
                    end
                end

                conway_cell_next #(
                    .SURV_MIN  (SURV_MIN),
                    .SURV_MAX  (SURV_MAX),
                    .BIRTH_MIN (BIRTH_MIN),
                    .BIRTH_MAX (BIRTH_MAX)
                ) u_next (
                    .nbr_i  (nbr_s),
                    .cell_i (cells_q[CIDX]),
                    .next_o (next_s[CIDX])
                );
            end
        end
    end

    // Control state transitions.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SETUP: begin
                if (BtnR) state_d = ST_SIMUL;
                else      state_d = ST_SETUP;
            end
            ST_SIMUL: begin
                if (BtnL)      state_d = ST_SETUP;
                else if (!Sw0) state_d = ST_PAUSE;
                else           state_d = ST_SIMUL;
            end
            ST_PAUSE: begin
                if (BtnL)     state_d = ST_SETUP;
                else if (Sw0) state_d = ST_SIMUL;
                else          state_d = ST_PAUSE;
            end
            default: state_d = ST_SETUP;
        endcase
    end

    // Tick counter and generation counter; both restart when a run begins.
    always_comb begin
        tick_d = tick_q;
        gen_d  = gen_q;
        case (state_q)
            ST_SETUP: begin
                if (BtnR) begin
                    tick_d = '0;
                    gen_d  = 16'd0;
                end else begin
                    tick_d = tick_q;
                    gen_d  = gen_q;
                end
            end
            ST_SIMUL: begin
                if (tick_last_s) begin
                    tick_d = '0;
                    gen_d  = (gen_q == 16'hFFFF) ? gen_q : gen_q + 16'd1;
                end else begin
                    tick_d = tick_q + TW'(1);
                    gen_d  = gen_q;
                end
            end
            default: begin
                tick_d = tick_q;
                gen_d  = gen_q;
            end
        endcase
    end

    // Cell array: edits in SETUP (even on the leaving edge), whole-array step at generation end.
    always_comb begin
        cells_d = cells_q;
        if (state_q == ST_SETUP) begin
            if (WrEn) cells_d[WrAddr] = WrData;
            else      cells_d = cells_q;
        end else if ((state_q == ST_SIMUL) && tick_last_s) begin
            cells_d = next_s;
        end else begin
            cells_d = cells_q;
        end
    end

    // All architectural state; async reset drops any in-flight generation.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_SETUP;
            tick_q  <= '0;
            gen_q   <= 16'd0;
            cells_q <= '0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            gen_q   <= gen_d;
            cells_q <= cells_d;
        end
    end

    assign Cells    = cells_q;
    assign GenCount = gen_q;
    assign Extinct  = ~|cells_q;
    assign q_setup  = state_q[2];
    assign q_simul  = state_q[1];
    assign q_pause  = state_q[0];

endmodule

// File: tb/tb_conway_engine.sv
// Directed scoreboard bench for conway_engine (N=8, TICK_DIV=4).
module tb_conway_engine;

    localparam int N  = 8;
    localparam int NC = N * N * N;

    logic           Clk;
    logic           Reset;
    logic           BtnR;
    logic           BtnL;
    logic           Sw0;
    logic           WrEn;
    logic [8:0]     WrAddr;
    logic           WrData;
    logic [NC-1:0]  Cells;
    logic [15:0]    GenCount;
    logic           Extinct;
    logic           q_setup;
    logic           q_simul;
    logic           q_pause;

    conway_engine #(
        .N         (8),
        .TICK_DIV  (4),
        .SURV_MIN  (4),
        .SURV_MAX  (5),
        .BIRTH_MIN (5),
        .BIRTH_MAX (5)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .BtnR     (BtnR),
        .BtnL     (BtnL),
        .Sw0      (Sw0),
        .WrEn     (WrEn),
        .WrAddr   (WrAddr),
        .WrData   (WrData),
        .Cells    (Cells),
        .GenCount (GenCount),
        .Extinct  (Extinct),
        .q_setup  (q_setup),
        .q_simul  (q_simul),
        .q_pause  (q_pause)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        string         tag;
        logic [NC-1:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic int idx(input int x, input int y, input int z);
        return x + 8 * y + 64 * z;
    endfunction

    // Reference step of the 3D rule, written directly from coordinates.
    function automatic logic [NC-1:0] model_next(input logic [NC-1:0] c);
        logic [NC-1:0] r;
        int cnt, nx, ny, nz;
        r = '0;
        for (int z = 0; z < 8; z++)
            for (int y = 0; y < 8; y++)
                for (int x = 0; x < 8; x++) begin
                    cnt = 0;
                    for (int dz = -1; dz <= 1; dz++)
                        for (int dy = -1; dy <= 1; dy++)
                            for (int dx = -1; dx <= 1; dx++) begin
                                if (dx != 0 || dy != 0 || dz != 0) begin
                                    nx = x + dx; ny = y + dy; nz = z + dz;
`ifdef CONWAY_WRAP_EN
                                    nx = (nx + 8) % 8; ny = (ny + 8) % 8; nz = (nz + 8) % 8;
                                    cnt += int'(c[idx(nx, ny, nz)]);
`else
                                    if (nx >= 0 && nx < 8 && ny >= 0 && ny < 8 && nz >= 0 && nz < 8)
                                        cnt += int'(c[idx(nx, ny, nz)]);
`endif
                                end
                            end
                    if (c[idx(x, y, z)]) r[idx(x, y, z)] = (cnt >= 4 && cnt <= 5);
                    else                 r[idx(x, y, z)] = (cnt == 5);
                end
        return r;
    endfunction

    task automatic push(input string tag, input logic [NC-1:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic check(input logic [NC-1:0] obs);
        exp_t e;
        checks++;
        assert (sb_q.size() != 0) else begin
            errors++;
            $error("FAIL scoreboard_empty: observed %0h required a queued expectation", obs);
        end
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic write_cell(input int x, input int y, input int z, input logic v, input logic go);
        WrEn   = 1'b1;
        WrAddr = 9'(idx(x, y, z));
        WrData = v;
        BtnR   = go;
        tick(1);
        WrEn   = 1'b0;
        BtnR   = 1'b0;
    endtask

    task automatic pulse_reset();
        Reset = 1'b1;
        #2;
        Reset = 1'b0;
    endtask

    logic [NC-1:0] pat, g1, g2, g3;
    logic [2:0]    st;

    assign st = {q_setup, q_simul, q_pause};

    initial begin
        Reset = 1'b1; BtnR = 1'b0; BtnL = 1'b0; Sw0 = 1'b0;
        WrEn = 1'b0; WrAddr = 9'd0; WrData = 1'b0;

        // Reset state
        #3;
        push("rst_cells", '0);        check(Cells);
        push("rst_gen", '0);          check(GenCount);
        push("rst_state", 3'b100);    check(st);
        push("rst_extinct", 1'b1);    check(Extinct);
        @(negedge Clk);
        Reset = 1'b0;
        tick(1);

        // BtnL is ignored in SETUP
        BtnL = 1'b1;
        tick(1);
        BtnL = 1'b0;
        push("setup_btnl_ignored", 3'b100); check(st);

        // Single isolated cell, written on the edge that leaves SETUP
        Sw0 = 1'b1;
        pat = '0;
        pat[idx(3, 3, 3)] = 1'b1;
        write_cell(3, 3, 3, 1'b1, 1'b1);
        push("single_write_on_exit", pat); check(Cells);
        push("single_state_simul", 3'b010); check(st);
        push("single_gen_start", 16'd0);    check(GenCount);
        tick(3);
        push("single_gen_before_tick", 16'd0); check(GenCount);
        tick(1);
        push("single_cells_dead", '0);  check(Cells);
        push("single_extinct", 1'b1);   check(Extinct);
        push("single_gen1", 16'd1);     check(GenCount);
        tick(4);
        push("extinct_keeps_counting", 16'd2); check(GenCount);

        // Birth in the z=0 plane, then pause/resume and BtnL priority
        pulse_reset();
        tick(1);
        pat = '0;
        pat[idx(0, 0, 0)] = 1'b1; pat[idx(1, 0, 0)] = 1'b1; pat[idx(2, 0, 0)] = 1'b1;
        pat[idx(0, 1, 0)] = 1'b1; pat[idx(2, 1, 0)] = 1'b1;
        write_cell(0, 0, 0, 1'b1, 1'b0);
        write_cell(1, 0, 0, 1'b1, 1'b0);
        write_cell(2, 0, 0, 1'b1, 1'b0);
        write_cell(0, 1, 0, 1'b1, 1'b0);
        write_cell(2, 1, 0, 1'b1, 1'b1);
        g1 = model_next(pat);
        g2 = model_next(g1);
        g3 = model_next(g2);
        tick(4);
        push("birth_cell_110", 1'b1); check(Cells[idx(1, 1, 0)]);
        push("birth_gen1_cells", g1); check(Cells);
        push("birth_gen1_count", 16'd1); check(GenCount);
        tick(4);
        push("birth_gen2_cells", g2); check(Cells);
        push("birth_gen2_count", 16'd2); check(GenCount);

        tick(2);
        Sw0 = 1'b0;
        tick(1);
        WrEn = 1'b1; WrAddr = 9'(idx(6, 6, 6)); WrData = 1'b1;
        tick(10);
        WrEn = 1'b0;
        push("pause_state", 3'b001);   check(st);
        push("pause_gen_hold", 16'd2); check(GenCount);
        push("pause_cells_hold", g2);  check(Cells);
        Sw0 = 1'b1;
        tick(1);
        push("resume_state", 3'b010);   check(st);
        push("resume_no_update", 16'd2); check(GenCount);
        tick(1);
        push("resume_gen3_count", 16'd3); check(GenCount);
        push("resume_gen3_cells", g3);    check(Cells);
        Sw0 = 1'b0;
        tick(1);
        push("pause_again", 3'b001); check(st);
        Sw0 = 1'b1; BtnL = 1'b1;
        tick(1);
        BtnL = 1'b0;
        push("btnl_priority", 3'b100);  check(st);
        push("setup_cells_kept", g3);   check(Cells);

        // Edge wrap behaviour around cell (0,0,0)
        pulse_reset();
        tick(1);
        pat = '0;
        pat[idx(7, 0, 0)] = 1'b1; pat[idx(7, 1, 0)] = 1'b1; pat[idx(7, 7, 0)] = 1'b1;
        pat[idx(7, 0, 1)] = 1'b1; pat[idx(7, 0, 7)] = 1'b1;
        write_cell(7, 0, 0, 1'b1, 1'b0);
        write_cell(7, 1, 0, 1'b1, 1'b0);
        write_cell(7, 7, 0, 1'b1, 1'b0);
        write_cell(7, 0, 1, 1'b1, 1'b0);
        write_cell(7, 0, 7, 1'b1, 1'b1);
        g1 = model_next(pat);
        tick(4);
`ifdef CONWAY_WRAP_EN
        push("wrap_cell_000", 1'b1);
`else
        push("wrap_cell_000", 1'b0);
`endif
        check(Cells[idx(0, 0, 0)]);
        push("wrap_gen1_cells", g1); check(Cells);

        // Writes are ignored while simulating
        WrEn = 1'b1; WrAddr = 9'(idx(4, 4, 4)); WrData = 1'b1;
        tick(1);
        push("simul_write_ignored_a", g1); check(Cells);
        WrAddr = 9'(idx(3, 5, 2));
        tick(1);
        WrEn = 1'b0;
        push("simul_write_ignored_b", g1); check(Cells);

        // Asynchronous reset between edges, mid-generation
        #2;
        Reset = 1'b1;
        #1;
        push("async_rst_cells", '0);     check(Cells);
        push("async_rst_gen", 16'd0);    check(GenCount);
        push("async_rst_state", 3'b100); check(st);
        push("async_rst_extinct", 1'b1); check(Extinct);
        #1;
        Reset = 1'b0;
        tick(3);
        push("post_rst_setup", 3'b100); check(st);
        push("post_rst_cells", '0);     check(Cells);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
